// File: rtl/ex_mem_pipe_pkg.sv
// Shared definitions for the EX->MEM pipeline register.
//   - Bit positions inside the 2-bit MEMcontrols and WBcontrols bundles.
//   - Default datapath and register-index widths.
//   - Index of the hardwired-zero register R0.
package ex_mem_pipe_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 4;

  // MEMcontrols bundle: [1]=memRead, [0]=memWrite
  localparam int MEMREAD_B  = 1;
  localparam int MEMWRITE_B = 0;

  // WBcontrols bundle: [1]=regWrite, [0]=memToReg
  localparam int REGWRITE_B = 1;
  localparam int MEMTOREG_B = 0;

  localparam int R0_IDX = 0;

endpackage

// File: rtl/ex_mem_pipe_reg_en.sv
// pipe_reg_en: width-parameterised pipeline flop.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low clear
//   en    - load d when high (hold otherwise)
//   clr   - synchronous clear, wins over en
//   d     - next value
//   q     - registered value
module pipe_reg_en #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline register.
// Captures EX results with one cycle of latency, holds on stall, squashes on
// flush (flush wins over stall), gates the control bits of invalid slots, and
// forwards WB write data into the store-data path so a store that directly
// follows a producing instruction writes the fresh value.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   stall, flush            pipeline hold / squash
//   ex_*                    EX-stage slot being captured
//   wb_regWrite/wb_rd/wb_data  WB-stage register write (forwarding source)
//   mem_*                   registered MEM-stage slot
//   mem_regBData            store data after forwarding (combinational)
//   mem_halt                sticky: a valid HLT has reached MEM
//   mem_fwd_hit             forwarding applied this cycle
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_aluOut,
  input  logic [DATA_W-1:0] ex_regBData,
  input  logic [1:0]        ex_MEMcontrols,
  input  logic [1:0]        ex_WBcontrols,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_halt,
  input  logic              wb_regWrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_aluOut,
  output logic [DATA_W-1:0] mem_regBData,
  output logic [1:0]        mem_MEMcontrols,
  output logic [1:0]        mem_WBcontrols,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_halt,
  output logic              mem_fwd_hit
);

  localparam logic [REG_AW-1:0] R0 = REG_AW'(R0_IDX);

  logic              load;
  logic [1:0]        memCtlD;
  logic [1:0]        wbCtlD;
  logic              haltSet;
  logic [DATA_W-1:0] regBDataQ;
  logic [REG_AW-1:0] rtQ;

  assign load = !stall;

  // Control gating applied on capture. An invalid slot carries no controls;
  // writes to R0 are dropped; a read+write combination degrades to a write.
  // Once HLT is in MEM, every later slot loses its architectural writes.
  always_comb begin
    memCtlD = '0;
    wbCtlD  = '0;
    if (ex_valid) begin
      memCtlD = ex_MEMcontrols;
      if (ex_MEMcontrols[MEMREAD_B] && ex_MEMcontrols[MEMWRITE_B]) begin
        memCtlD[MEMREAD_B] = 1'b0;
      end
      wbCtlD[REGWRITE_B] = ex_WBcontrols[REGWRITE_B] && (ex_rd != R0);
      wbCtlD[MEMTOREG_B] = ex_WBcontrols[MEMTOREG_B];
      if (mem_halt) begin
        memCtlD[MEMWRITE_B] = 1'b0;
        wbCtlD[REGWRITE_B]  = 1'b0;
      end
    end
  end

  // Halt only ever sets; a flush or stall on the loading edge blocks it.
  assign haltSet = load && !flush && ex_valid && ex_halt;

  pipe_reg_en #(.W(1)) uValid (
    .clk(clk), .rst_n(rst_n), .en(load), .clr(flush), .d(ex_valid), .q(mem_valid)
  );

  pipe_reg_en #(.W(DATA_W)) uAluOut (
    .clk(clk), .rst_n(rst_n), .en(load), .clr(flush), .d(ex_aluOut), .q(mem_aluOut)
  );

  pipe_reg_en #(.W(DATA_W)) uRegBData (
    .clk(clk), .rst_n(rst_n), .en(load), .clr(flush), .d(ex_regBData), .q(regBDataQ)
  );

  pipe_reg_en #(.W(2)) uMemCtl (
    .clk(clk), .rst_n(rst_n), .en(load), .clr(flush), .d(memCtlD), .q(mem_MEMcontrols)
  );

  pipe_reg_en #(.W(2)) uWbCtl (
    .clk(clk), .rst_n(rst_n), .en(load), .clr(flush), .d(wbCtlD), .q(mem_WBcontrols)
  );

  pipe_reg_en #(.W(REG_AW)) uRd (
    .clk(clk), .rst_n(rst_n), .en(load), .clr(flush), .d(ex_rd), .q(mem_rd)
  );

  pipe_reg_en #(.W(REG_AW)) uRt (
    .clk(clk), .rst_n(rst_n), .en(load), .clr(flush), .d(ex_rt), .q(rtQ)
  );

  pipe_reg_en #(.W(1)) uHalt (
    .clk(clk), .rst_n(rst_n), .en(haltSet), .clr(1'b0), .d(1'b1), .q(mem_halt)
  );

  // WB->MEM store-data forwarding. Evaluated every cycle against the current
  // WB stage, so a stalled store picks up a producer that arrives later.
  assign mem_fwd_hit  = mem_valid && mem_MEMcontrols[MEMWRITE_B] && wb_regWrite &&
                        (wb_rd != R0) && (wb_rd == rtQ);
  assign mem_regBData = mem_fwd_hit ? wb_data : regBDataQ;

endmodule

// File: tb/tb_ex_mem_pipe.sv
module tb_ex_mem_pipe;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              stall, flush, ex_valid, ex_halt, wb_regWrite;
  logic [DATA_W-1:0] ex_aluOut, ex_regBData, wb_data;
  logic [1:0]        ex_MEMcontrols, ex_WBcontrols;
  logic [REG_AW-1:0] ex_rd, ex_rt, wb_rd;
  logic              mem_valid, mem_halt, mem_fwd_hit;
  logic [DATA_W-1:0] mem_aluOut, mem_regBData;
  logic [1:0]        mem_MEMcontrols, mem_WBcontrols;
  logic [REG_AW-1:0] mem_rd;

  ex_mem_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_aluOut(ex_aluOut), .ex_regBData(ex_regBData),
    .ex_MEMcontrols(ex_MEMcontrols), .ex_WBcontrols(ex_WBcontrols),
    .ex_rd(ex_rd), .ex_rt(ex_rt), .ex_halt(ex_halt),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_valid(mem_valid), .mem_aluOut(mem_aluOut), .mem_regBData(mem_regBData),
    .mem_MEMcontrols(mem_MEMcontrols), .mem_WBcontrols(mem_WBcontrols),
    .mem_rd(mem_rd), .mem_halt(mem_halt), .mem_fwd_hit(mem_fwd_hit)
  );

  // ---------------- checker ----------------
  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // The MEM slot as an instruction record plus the sticky halt flag.
  logic              mValid, mHalt;
  logic [DATA_W-1:0] mAlu, mRegB;
  logic [1:0]        mMem, mWb;
  logic [REG_AW-1:0] mRd, mRt;

  task automatic modelReset();
    mValid = 0; mHalt = 0; mAlu = 0; mRegB = 0; mMem = 0; mWb = 0; mRd = 0; mRt = 0;
  endtask

  task automatic modelEdge();
    if (flush) begin
      mValid = 0; mAlu = 0; mRegB = 0; mMem = 0; mWb = 0; mRd = 0; mRt = 0;
    end else if (!stall) begin
      mValid = ex_valid; mAlu = ex_aluOut; mRegB = ex_regBData; mRd = ex_rd; mRt = ex_rt;
      if (ex_valid) begin
        mMem = (ex_MEMcontrols == 2'b11) ? 2'b01 : ex_MEMcontrols;
        mWb  = {ex_WBcontrols[1] && (ex_rd != 0), ex_WBcontrols[0]};
        if (mHalt) begin
          mMem[0] = 1'b0;
          mWb[1]  = 1'b0;
        end
        if (ex_halt) mHalt = 1'b1;
      end else begin
        mMem = 0; mWb = 0;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    logic expHit;
    logic [DATA_W-1:0] expData;
    expHit  = mValid && mMem[0] && wb_regWrite && (wb_rd != 0) && (wb_rd == mRt);
    expData = expHit ? wb_data : mRegB;
    chk({tag, ".valid"}, 32'(mem_valid),       32'(mValid));
    chk({tag, ".alu"},   32'(mem_aluOut),      32'(mAlu));
    chk({tag, ".regB"},  32'(mem_regBData),    32'(expData));
    chk({tag, ".memc"},  32'(mem_MEMcontrols), 32'(mMem));
    chk({tag, ".wbc"},   32'(mem_WBcontrols),  32'(mWb));
    chk({tag, ".rd"},    32'(mem_rd),          32'(mRd));
    chk({tag, ".halt"},  32'(mem_halt),        32'(mHalt));
    chk({tag, ".hit"},   32'(mem_fwd_hit),     32'(expHit));
  endtask

  // ---------------- driver tasks ----------------
  task automatic clearIn();
    stall = 0; flush = 0; ex_valid = 0; ex_halt = 0; wb_regWrite = 0;
    ex_aluOut = 0; ex_regBData = 0; wb_data = 0;
    ex_MEMcontrols = 0; ex_WBcontrols = 0; ex_rd = 0; ex_rt = 0; wb_rd = 0;
  endtask

  // Advance one edge (inputs held stable across it), then check 1 unit later.
  task automatic step(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(tag);
  endtask

  // Mid-cycle asynchronous reset pulse; called just after a step.
  task automatic pulseReset(input string tag);
    #2 rst_n = 0;
    modelReset();
    #1 checkAll(tag);
    #1 rst_n = 1;
  endtask

  task automatic randIn();
    stall          = ($urandom_range(0, 4) == 0);
    flush          = ($urandom_range(0, 7) == 0);
    ex_valid       = ($urandom_range(0, 3) != 0);
    ex_halt        = ($urandom_range(0, 40) == 0);
    ex_aluOut      = DATA_W'($urandom);
    ex_regBData    = DATA_W'($urandom);
    ex_MEMcontrols = 2'($urandom_range(0, 3));
    ex_WBcontrols  = 2'($urandom_range(0, 3));
    ex_rd          = REG_AW'($urandom_range(0, 3));
    ex_rt          = REG_AW'($urandom_range(0, 3));
    wb_regWrite    = ($urandom_range(0, 1) == 1);
    wb_rd          = REG_AW'($urandom_range(0, 3));
    wb_data        = DATA_W'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clearIn();
    modelReset();
    #12 rst_n = 1;
    checkAll("reset");

    // Basic load
    ex_valid = 1; ex_aluOut = 16'h1234; ex_MEMcontrols = 2'b10; ex_WBcontrols = 2'b11; ex_rd = 3;
    step("load");
    chk("load.alu_const",  32'(mem_aluOut),      32'h1234);
    chk("load.memc_const", 32'(mem_MEMcontrols), 32'h2);
    chk("load.wbc_const",  32'(mem_WBcontrols),  32'h3);
    chk("load.valid_const", 32'(mem_valid),      32'h1);

    // Mid-cycle reset with nonzero outputs
    pulseReset("midreset");
    chk("midreset.alu_const", 32'(mem_aluOut), 32'h0);

    // Stall holds A against new EX data, then stall+flush squashes
    ex_aluOut = 16'hA1A1; ex_rd = 6;
    step("loadA");
    stall = 1; ex_aluOut = 16'hBBBB; ex_rd = 9;
    step("stall1");
    step("stall2");
    chk("stall.alu_const", 32'(mem_aluOut), 32'hA1A1);
    flush = 1;
    step("stallflush");
    chk("flush.valid_const", 32'(mem_valid),       32'h0);
    chk("flush.memc_const",  32'(mem_MEMcontrols), 32'h0);

    // Gating
    stall = 0; flush = 0; ex_valid = 0; ex_MEMcontrols = 2'b01;
    step("gate_invalid");
    chk("gate_invalid.memc_const", 32'(mem_MEMcontrols), 32'h0);
    ex_valid = 1; ex_rd = 0; ex_WBcontrols = 2'b10; ex_MEMcontrols = 2'b11;
    step("gate_r0");
    chk("gate_r0.wbc_const",  32'(mem_WBcontrols),  32'h0);
    chk("gate_rw.memc_const", 32'(mem_MEMcontrols), 32'h1);

    // Forwarding
    ex_MEMcontrols = 2'b01; ex_WBcontrols = 2'b00; ex_rd = 7; ex_rt = 5; ex_regBData = 16'hAAAA;
    wb_regWrite = 1; wb_rd = 5; wb_data = 16'h5555;
    step("fwd");
    chk("fwd.data_const", 32'(mem_regBData), 32'h5555);
    chk("fwd.hit_const",  32'(mem_fwd_hit),  32'h1);
    wb_rd = 0;
    #1 checkAll("fwd_r0");
    chk("fwd_r0.data_const", 32'(mem_regBData), 32'hAAAA);
    // Stalled store re-evaluates forwarding against the live WB stage
    stall = 1; wb_rd = 5; wb_data = 16'h7777;
    step("fwd_stall");
    chk("fwd_stall.data_const", 32'(mem_regBData), 32'h7777);
    stall = 0; ex_MEMcontrols = 2'b10;
    step("fwd_nowrite");
    chk("fwd_nowrite.data_const", 32'(mem_regBData), 32'hAAAA);
    chk("fwd_nowrite.hit_const",  32'(mem_fwd_hit),  32'h0);

    // Halt: sticky, blocks later stores
    wb_regWrite = 0; ex_halt = 1; ex_MEMcontrols = 2'b00;
    step("halt");
    chk("halt.set_const", 32'(mem_halt), 32'h1);
    ex_halt = 0; ex_MEMcontrols = 2'b01; ex_WBcontrols = 2'b10; ex_rd = 4;
    step("halt_store");
    chk("halt_store.memc_const", 32'(mem_MEMcontrols), 32'h0);
    chk("halt_store.sticky",     32'(mem_halt),        32'h1);
    ex_valid = 0;
    step("halt_bubble");

    // Flush on the loading edge blocks halt capture
    pulseReset("reset_halt");
    ex_valid = 1; ex_halt = 1; flush = 1;
    step("halt_flushed");
    chk("halt_flushed.const", 32'(mem_halt), 32'h0);

    // Reset while stalled and flushing leaves nothing pending
    flush = 0; ex_halt = 0; ex_aluOut = 16'h4321;
    step("pre_rstall");
    stall = 1; flush = 1;
    pulseReset("rst_stallflush");
    flush = 0;
    step("after_rstall");

    // Randomized traffic against the model
    stall = 0;
    for (int i = 0; i < 600; i++) begin
      randIn();
      step("rand");
      if ($urandom_range(0, 60) == 0) pulseReset("rand_reset");
      if ($urandom_range(0, 3) == 0) begin
        wb_regWrite = ($urandom_range(0, 1) == 1);
        wb_rd       = REG_AW'($urandom_range(0, 3));
        wb_data     = DATA_W'($urandom);
        #1 checkAll("rand_wb");
      end
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
